sc_mm_controller: RTL and testbench
===================================

# sc_mm_controller

Sequencing controller for the stochastic-computing matrix-multiply datapath (SNG banks, SC matrix multiply array, stochastic-to-digital converters). On `start` it fetches one weight matrix, then for each of `num_tiles` input batches: fetches the input matrix, loads the SNGs, runs the stochastic stream for a fixed length, drains the pipeline and hands the converted output matrix to the output memory under an ack handshake. It sits between the top-level wrapper's memory ports and the datapath enables.

## Interface
- `BINARY_PRECISION`, 8: SNG/converter bit width; stream length base is 2^BINARY_PRECISION.
- `STOCHASTIC_CYCLES`, 1: number of full 2^BINARY_PRECISION streams per tile.
- `PIPE_DEPTH`, 2: datapath latency (SNG to converter input) drained after RUN; ≥1.
- `ADDR_WIDTH`, 10: width of all memory addresses.
- `TILE_WIDTH`, 8: width of `num_tiles` and the tile counter.

- `clk`  in  1  single clock.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a job; sampled only in IDLE.
- `num_tiles`  in  TILE_WIDTH  tiles in job; captured at start; 0 is treated as 1.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse on job completion.
- `weightAddr`  out  ADDR_WIDTH  weight memory read address (always 0 in this revision; held).
- `inputAddr`  out  ADDR_WIDTH  input memory read address = tile index.
- `sng_load`  out  1  one-cycle pulse: SNGs capture memory read data.
- `sng_en`  out  1  SNGs advance.
- `conv_clr`  out  1  one-cycle pulse: converters clear counts.
- `conv_en`  out  1  converters accumulate.
- `outAddr`  out  ADDR_WIDTH  output memory write address = tile index.
- `outputWrEn`  out  1  output matrix valid; held until `out_ack`.
- `out_ack`  in  1  output memory accepted the write.
- `perf_cycles`  out  32  busy-cycle counter (only with SC_MM_CTRL_PERF_EN).

## Operation
- States: IDLE, FETCH_W, FETCH_I, LOAD, RUN, FLUSH, WRITE, DONE.
- IDLE: `start`=1 → FETCH_W; capture `num_tiles`, tile counter ← 0.
- FETCH_W: `weightAddr` presented; one cycle (memory read latency 1) → FETCH_I.
- FETCH_I: `inputAddr` = tile; one cycle → LOAD.
- LOAD: `sng_load`=1, `conv_clr`=1 for one cycle → RUN; stream counter ← 0.
- RUN: `sng_en`=`conv_en`=1 for exactly STOCHASTIC_CYCLES·2^BINARY_PRECISION cycles → FLUSH.
- FLUSH: `sng_en`=0, `conv_en`=1 for PIPE_DEPTH cycles → WRITE.
- WRITE: `outputWrEn`=1, `outAddr`=tile; stays until `out_ack`=1. On ack: last tile → DONE, else tile+1, → FETCH_I (weights reused, not refetched).
- DONE: `done`=1 one cycle → IDLE.
- Stream counter width: BINARY_PRECISION+$clog2(STOCHASTIC_CYCLES)+1; terminal compare, no wrap.
- `start` outside IDLE ignored; `out_ack` outside WRITE ignored.
- Address outputs hold their last value outside fetch/write states.

## Timing
- Reset (asynchronous assert, synchronous release): state IDLE; all outputs 0, counters 0.
- Reset mid-job: immediate return to IDLE, no `done`, no write.
- Job cycle count with immediate ack: 2 (FETCH_W/FETCH_I first tile) + per tile [1 LOAD + L RUN + PIPE_DEPTH + 1 WRITE] + (tiles−1) FETCH_I + 1 DONE, L = STOCHASTIC_CYCLES·2^BINARY_PRECISION.
- `out_ack` in same cycle WRITE is entered completes the write in that cycle.
- `done` asserted the cycle after final ack; `busy` falls the cycle after `done`.

## Configuration
- `SC_MM_CTRL_PERF_EN` defined: `perf_cycles` exists, cleared on `start` acceptance, increments each cycle `busy`=1, saturates at 2^32−1, holds after job.
- Undefined: port and counter absent; no other behaviour change.

## Structure
- Package `sc_pkg`: state enum encoding, stream-length function of BINARY_PRECISION/STOCHASTIC_CYCLES, shared address width default.
- One sub-module natural: `sc_stream_counter` (loadable terminal-count counter) reused for RUN and FLUSH.

## Test plan
- BINARY_PRECISION=4, STOCHASTIC_CYCLES=1, PIPE_DEPTH=2, num_tiles=1, ack immediate → `sng_en` high exactly 16 cycles, `conv_en` 18, one `outputWrEn` at outAddr 0, `done` 23 cycles after start.
- num_tiles=3 → inputAddr/outAddr sequence 0,1,2; `sng_load` 3 pulses; weightAddr phase once.
- Ack delayed 5 cycles in tile 1 → `outputWrEn` held 6 cycles, next FETCH_I only after ack, sng_en stays 0 meanwhile.
- `rst` low mid-RUN → all outputs 0 asynchronously, no `done`; new start runs a full job correctly.
- num_tiles=0 → behaves as 1 tile; `start` pulsed while busy → ignored, tile count unchanged.
- With SC_MM_CTRL_PERF_EN, first scenario → `perf_cycles`=23 after `done`, held thereafter.

Source files
------------

// File: rtl/sc_pkg.sv
// sc_pkg: state encoding, stream-length helper and address-width default shared by the
// stochastic-computing matrix-multiply controller.
package sc_pkg;
  localparam int ADDR_WIDTH_DEF = 10;
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH_W, S_FETCH_I, S_LOAD, S_RUN, S_FLUSH, S_WRITE, S_DONE
  } state_t;
  function automatic int stream_len(input int bp, input int sc);
    return sc << bp;
  endfunction
endpackage

// File: rtl/sc_stream_counter.sv
// sc_stream_counter: clearable up-counter flagging when it sits on a terminal value.
module sc_stream_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] term_i,
  output logic         tc_o
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr_i ? '0 : en_i ? cnt_q + W'(1) : cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign tc_o = cnt_q == term_i;
endmodule

// File: rtl/sc_mm_controller.sv
// sc_mm_controller: job sequencer for the SC matrix-multiply datapath.
// Optional busy-cycle counter perf_cycles when SC_MM_CTRL_PERF_EN is defined.
module sc_mm_controller
  import sc_pkg::*;
#(
  parameter int BINARY_PRECISION  = 8,
  parameter int STOCHASTIC_CYCLES = 1,
  parameter int PIPE_DEPTH        = 2,
  parameter int ADDR_WIDTH        = ADDR_WIDTH_DEF,
  parameter int TILE_WIDTH        = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [TILE_WIDTH-1:0] num_tiles,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] weightAddr,
  output logic [ADDR_WIDTH-1:0] inputAddr,
  output logic                  sng_load,
  output logic                  sng_en,
  output logic                  conv_clr,
  output logic                  conv_en,
  output logic [ADDR_WIDTH-1:0] outAddr,
  output logic                  outputWrEn,
`ifdef SC_MM_CTRL_PERF_EN
  output logic [31:0]           perf_cycles,
`endif
  input  logic                  out_ack
);
  localparam int CW = BINARY_PRECISION + $clog2(STOCHASTIC_CYCLES) + 1;
  localparam logic [CW-1:0] RUN_LAST   = CW'(stream_len(BINARY_PRECISION, STOCHASTIC_CYCLES) - 1);
  localparam logic [CW-1:0] FLUSH_LAST = CW'(PIPE_DEPTH - 1);
  state_t state_q, state_d;
  logic [TILE_WIDTH-1:0] tile_q, tile_d, last_q, last_d;
  logic [ADDR_WIDTH-1:0] ia_q, ia_d, oa_q, oa_d;
  logic cnt_clr, tc;
  always_comb begin
    state_d = state_q;
    tile_d  = tile_q;
    last_d  = last_q;
    ia_d    = ia_q;
    oa_d    = oa_q;
    cnt_clr = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_FETCH_W;
        tile_d  = '0;
        last_d  = num_tiles == '0 ? '0 : num_tiles - TILE_WIDTH'(1);
      end
      S_FETCH_W: begin
        state_d = S_FETCH_I;
        ia_d    = ADDR_WIDTH'(tile_q);
      end
      S_FETCH_I: state_d = S_LOAD;
      S_LOAD: begin
        state_d = S_RUN;
        cnt_clr = 1'b1;
      end
      S_RUN: if (tc) begin
        state_d = S_FLUSH;
        cnt_clr = 1'b1;
      end
      S_FLUSH: if (tc) begin
        state_d = S_WRITE;
        oa_d    = ADDR_WIDTH'(tile_q);
      end
      // Weights stay resident across tiles, so the next tile re-enters at FETCH_I.
      S_WRITE: if (out_ack) begin
        state_d = tile_q == last_q ? S_DONE : S_FETCH_I;
        tile_d  = tile_q == last_q ? tile_q : tile_q + TILE_WIDTH'(1);
        ia_d    = tile_q == last_q ? ia_q : ADDR_WIDTH'(tile_q + TILE_WIDTH'(1));
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= S_IDLE;
      tile_q  <= '0;
      last_q  <= '0;
      ia_q    <= '0;
      oa_q    <= '0;
    end else begin
      state_q <= state_d;
      tile_q  <= tile_d;
      last_q  <= last_d;
      ia_q    <= ia_d;
      oa_q    <= oa_d;
    end
  sc_stream_counter #(.W(CW)) u_cnt (
    .clk   (clk),
    .rst_n (rst),
    .clr_i (cnt_clr),
    .en_i  (conv_en),
    .term_i(state_q == S_RUN ? RUN_LAST : FLUSH_LAST),
    .tc_o  (tc)
  );
  assign busy       = state_q != S_IDLE;
  assign done       = state_q == S_DONE;
  assign sng_load   = state_q == S_LOAD;
  assign conv_clr   = state_q == S_LOAD;
  assign sng_en     = state_q == S_RUN;
  assign conv_en    = state_q == S_RUN || state_q == S_FLUSH;
  assign outputWrEn = state_q == S_WRITE;
  assign weightAddr = '0;
  assign inputAddr  = ia_q;
  assign outAddr    = oa_q;
`ifdef SC_MM_CTRL_PERF_EN
  logic [31:0] perf_q, perf_d;
  always_comb
    perf_d = (state_q == S_IDLE && start) ? '0 : (busy && perf_q != '1) ? perf_q + 32'd1 : perf_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) perf_q <= '0;
    else perf_q <= perf_d;
  assign perf_cycles = perf_q;
`endif
endmodule

// File: tb/tb_sc_mm_controller.sv
// tb_sc_mm_controller: table-driven and randomized checks of sc_mm_controller against a
// cycle trace built from the job phase rules.
module tb_sc_mm_controller;
  localparam int BP = 4, SCY = 1, PD = 2, AW = 10, TW = 8, L = SCY << BP;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0, out_ack = 1'b0;
  logic [TW-1:0] num_tiles = '0;
  logic busy, done, sng_load, sng_en, conv_clr, conv_en, outputWrEn;
  logic [AW-1:0] weightAddr, inputAddr, outAddr;
`ifdef SC_MM_CTRL_PERF_EN
  logic [31:0] perf_cycles;
`endif
  always #5 clk = ~clk;

  sc_mm_controller #(
    .BINARY_PRECISION(BP), .STOCHASTIC_CYCLES(SCY), .PIPE_DEPTH(PD),
    .ADDR_WIDTH(AW), .TILE_WIDTH(TW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .num_tiles(num_tiles), .busy(busy), .done(done),
    .weightAddr(weightAddr), .inputAddr(inputAddr), .sng_load(sng_load), .sng_en(sng_en),
    .conv_clr(conv_clr), .conv_en(conv_en), .outAddr(outAddr), .outputWrEn(outputWrEn),
`ifdef SC_MM_CTRL_PERF_EN
    .perf_cycles(perf_cycles),
`endif
    .out_ack(out_ack)
  );

  typedef struct packed {
    logic busy, done, ld, sen, clr, cen, wr;
    logic [AW-1:0] wa, ia, oa;
  } obs_t;
  obs_t obs, idle_exp;
  assign obs = {busy, done, sng_load, sng_en, conv_clr, conv_en, outputWrEn, weightAddr, inputAddr, outAddr};

  obs_t eq[$];
  int aq[$];
  int n_chk = 0, n_fail = 0;
  int m_ia = 0, m_oa = 0;
  int dly[8];
  int lat, loads;

  typedef struct {int nt; int d; int lat; int loads;} vec_t;
  vec_t tbl[5];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic void push(input logic b, dn, ld, sen, clr, cen, wr, input int ack);
    eq.push_back(obs_t'({b, dn, ld, sen, clr, cen, wr, AW'(0), AW'(m_ia), AW'(m_oa)}));
    aq.push_back(ack);
  endfunction

  // Expected per-cycle trace of one job; ack value -1 means "don't care, drive noise".
  function automatic void build(input int nt);
    int n;
    n = nt == 0 ? 1 : nt;
    eq.delete();
    aq.delete();
    push(1, 0, 0, 0, 0, 0, 0, -1);
    for (int t = 0; t < n; t++) begin
      m_ia = t;
      push(1, 0, 0, 0, 0, 0, 0, -1);
      push(1, 0, 1, 0, 1, 0, 0, -1);
      for (int k = 0; k < L; k++) push(1, 0, 0, 1, 0, 1, 0, -1);
      for (int k = 0; k < PD; k++) push(1, 0, 0, 0, 0, 1, 0, -1);
      m_oa = t;
      for (int k = 0; k <= dly[t]; k++) push(1, 0, 0, 0, 0, 0, 1, k == dly[t] ? 1 : 0);
    end
    push(1, 1, 0, 0, 0, 0, 0, -1);
  endfunction

  task automatic run_job(input int nt, input string tag);
    build(nt);
    @(negedge clk);
    start = 1'b1;
    num_tiles = TW'(nt);
    out_ack = 1'($urandom_range(0, 1));
    lat = 0;
    loads = 0;
    foreach (eq[i]) begin
      @(negedge clk);
      chk($sformatf("%s cyc%0d", tag, i), obs, eq[i]);
      if (done && lat == 0) lat = i + 1;
      loads += int'(sng_load);
      start = 1'($urandom_range(0, 1));
      num_tiles = TW'($urandom);
      out_ack = aq[i] < 0 ? 1'($urandom_range(0, 1)) : (aq[i] == 1);
    end
    @(negedge clk);
    start = 1'b0;
    out_ack = 1'b0;
    idle_exp = obs_t'({7'b0, AW'(0), AW'(m_ia), AW'(m_oa)});
    chk($sformatf("%s idle after done", tag), obs, idle_exp);
`ifdef SC_MM_CTRL_PERF_EN
    chk($sformatf("%s perf_cycles", tag), perf_cycles, lat);
    @(negedge clk);
    chk($sformatf("%s perf_cycles held", tag), perf_cycles, lat);
`endif
  endtask

  initial begin
    tbl[0] = '{1, 0, 23, 1};
    tbl[1] = '{3, 0, 65, 3};
    tbl[2] = '{0, 0, 23, 1};
    tbl[3] = '{2, 5, 54, 2};
    tbl[4] = '{4, 1, 90, 4};

    repeat (3) @(negedge clk);
    chk("reset outputs", obs, '0);
    rst = 1'b1;
    @(negedge clk);
    out_ack = 1'b1;
    chk("after release idle", obs, '0);
    @(negedge clk);
    out_ack = 1'b0;
    chk("ack in idle ignored", obs, '0);

    for (int v = 0; v < 5; v++) begin
      for (int t = 0; t < 8; t++) dly[t] = tbl[v].d;
      run_job(tbl[v].nt, $sformatf("vec%0d", v));
      chk($sformatf("vec%0d done latency", v), lat, tbl[v].lat);
      chk($sformatf("vec%0d load pulses", v), loads, tbl[v].loads);
    end

    for (int t = 0; t < 8; t++) dly[t] = 0;
    dly[1] = 5;
    run_job(3, "ack-delay-tile1");
    chk("ack-delay latency", lat, 2 + 3 * 20 + 5 + 2 + 1);

    @(negedge clk);
    start = 1'b1;
    num_tiles = TW'(2);
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    chk("mid-run sng_en", sng_en, 1'b1);
    #2 rst = 1'b0;
    #1 chk("async reset outputs", obs, '0);
    m_ia = 0;
    m_oa = 0;
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("post-reset idle %0d", k), obs, '0);
    end
    for (int t = 0; t < 8; t++) dly[t] = 0;
    run_job(1, "after-reset");
    chk("after-reset latency", lat, 23);

    for (int r = 0; r < 6; r++) begin
      int nt;
      nt = $urandom_range(0, 4);
      for (int t = 0; t < 8; t++) dly[t] = $urandom_range(0, 4);
      run_job(nt, $sformatf("rand%0d", r));
      chk($sformatf("rand%0d load pulses", r), loads, nt == 0 ? 1 : nt);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
